// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared ASCII constants and collector state encoding for the UART path
package uart_pkg;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2,
      ERR     = 2'd3
   } state_t;

endpackage

// File: rtl/ascii_digit_decode.sv
// rtl/ascii_digit_decode.sv - classifies an ASCII byte as a decimal digit and yields its BCD nibble
module ascii_digit_decode
   import uart_pkg::*;
(
   input  logic [7:0] rx_data,
   output logic       is_digit,
   output logic [3:0] nibble
);

   always_comb begin
      is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
      nibble   = rx_data[3:0];
   end

endmodule

// File: rtl/uart_bcd_collector.sv
// rtl/uart_bcd_collector.sv - packs ASCII digits from UART RX into a BCD word, offered on valid/ready
module uart_bcd_collector
   import uart_pkg::*;
#(
   parameter int         DIGITS = 4,
   parameter logic [7:0] TERM   = ASCII_CR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  bcd_valid,
   input  logic                  bcd_ready,
   output logic [3:0]            digit_cnt,
   output logic                  err,
   output logic                  overrun
);

   localparam int         W      = 4 * DIGITS;
   localparam logic [3:0] MAXCNT = 4'(DIGITS);

   state_t         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   out_q, out_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           ovr_q, ovr_d;
   logic           is_digit;
   logic [3:0]     nibble;
   logic           is_term;

   ascii_digit_decode u_decode (
      .rx_data  (rx_data),
      .is_digit (is_digit),
      .nibble   (nibble)
   );

   assign is_term = (rx_data == TERM);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      // Any byte arriving while a result is on offer is lost, even on the accepting cycle.
      ovr_d   = (state_q == HOLD) && rx_valid;
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               if (is_digit) begin
                  acc_d   = W'(nibble);
                  cnt_d   = 4'd1;
                  state_d = COLLECT;
               end else if (!is_term) begin
                  acc_d   = '0;
                  cnt_d   = 4'd0;
                  state_d = ERR;
               end
            end
         end
         COLLECT: begin
            if (rx_valid) begin
               if (is_digit && (cnt_q < MAXCNT)) begin
                  acc_d = (acc_q << 4) | W'(nibble);
                  cnt_d = cnt_q + 4'd1;
               end else if (is_term && !is_digit) begin
                  out_d   = acc_q;
                  state_d = HOLD;
               end else begin
                  acc_d   = '0;
                  cnt_d   = 4'd0;
                  state_d = ERR;
               end
            end
         end
         HOLD: begin
            if (bcd_ready) begin
               acc_d   = '0;
               cnt_d   = 4'd0;
               state_d = IDLE;
            end
         end
         ERR: begin
            if (rx_valid && is_term) begin
               acc_d   = '0;
               cnt_d   = 4'd0;
               state_d = IDLE;
            end
         end
         default: begin
            acc_d   = '0;
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         out_q   <= '0;
         cnt_q   <= 4'd0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bcd_out   = out_q;
   assign bcd_valid = (state_q == HOLD);
   assign digit_cnt = cnt_q;
   assign err       = (state_q == ERR);
   assign overrun   = ovr_q;

endmodule
